// File: rtl/eco32f_serial_mul.sv
// Iterative shift-and-add multiplier with valid/ready request and response
// handshakes, signed/unsigned operands, low/high word select and flush.
module eco32f_serial_mul #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  input  logic             req_signed,
  input  logic             req_high,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     cnt;
  logic              neg;
  logic              high;

  logic [PW-1:0]     addend;
  logic [PW-1:0]     acc_next;
  logic [PW-1:0]     product;
  logic [WIDTH-1:0]  mag_x;
  logic [WIDTH-1:0]  mag_y;
  logic              accept;

  // Partial product for the low BITS_PER_CYCLE multiplier bits this step.
  always_comb begin
    addend = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) addend = addend + (mcand << i);
    end
    acc_next = acc + addend;
    product  = neg ? PW'(~acc_next + 1'b1) : acc_next;
  end

  // Two's complement magnitude; the most-negative value maps to itself as unsigned.
  always_comb begin
    mag_x  = (req_signed && req_x[WIDTH-1]) ? WIDTH'(~req_x + 1'b1) : req_x;
    mag_y  = (req_signed && req_y[WIDTH-1]) ? WIDTH'(~req_y + 1'b1) : req_y;
    accept = req_valid && req_ready && !flush && (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      busy       <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      high       <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RUN;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            acc       <= '0;
            mcand     <= PW'(mag_x);
            mplier    <= mag_y;
            cnt       <= CW'(STEPS);
            neg       <= req_signed && (req_x[WIDTH-1] ^ req_y[WIDTH-1]);
            high      <= req_high;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= CW'(cnt - 1'b1);
          if (cnt == CW'(1)) begin
            state      <= DONE;
            rsp_valid  <= 1'b1;
            rsp_result <= high ? product[PW-1:WIDTH] : product[WIDTH-1:0];
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eco32f_serial_mul.sv
// Bench for eco32f_serial_mul: directed corners plus random operands against
// a 64-bit arithmetic reference model.
module tb_eco32f_serial_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        req_signed;
  logic        req_high;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  eco32f_serial_mul #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_signed (req_signed),
    .req_high   (req_high),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s, input logic h);
    logic [63:0] p;
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = 64'(sx * sy);
    end else begin
      p = {32'd0, x} * {32'd0, y};
    end
    return h ? p[63:32] : p[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request, check latency and result, then apply 'hold' cycles of backpressure.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input logic h, input int hold);
    int edges;
    logic [31:0] exp;
    logic [31:0] first;
    exp = model(x, y, s, h);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    rsp_ready  = (hold == 0);
    req_valid  = 1'b1;
    req_x      = x;
    req_y      = y;
    req_signed = s;
    req_high   = h;
    tick();
    req_valid = 1'b0;
    req_x     = $urandom;
    req_y     = $urandom;
    edges = 1;
    while (!rsp_valid && edges < 100) begin
      tick();
      edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'd33);
    check({tag, "_result"}, 64'(rsp_result), 64'(exp));
    first = rsp_result;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_hold_result"}, 64'(rsp_result), 64'(first));
      check({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check({tag, "_post_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_post_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
    req_signed = 1'b0; req_high = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    #12;
    check("reset_ready", 64'(req_ready), 64'd1);
    check("reset_valid", 64'(rsp_valid), 64'd0);
    check("reset_result", 64'(rsp_result), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    tick();

    run_op("u_low", 32'h0000FFFF, 32'h00010001, 1'b0, 1'b0, 0);
    run_op("s_high", 32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b1, 0);
    check("s_high_const", 64'(rsp_result), 64'hFFFFFFFF);
    run_op("s_low", 32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b0, 0);
    check("s_low_const", 64'(rsp_result), 64'hFFFFFFFA);
    run_op("minneg_s", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 0);
    check("minneg_s_const", 64'(rsp_result), 64'h40000000);
    run_op("minneg_uh", 32'h80000000, 32'h80000000, 1'b0, 1'b1, 0);
    run_op("minneg_ul", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 0);
    run_op("ones_uh", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 0);
    check("ones_uh_const", 64'(rsp_result), 64'hFFFFFFFE);
    run_op("zero", 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 0);
    run_op("backpressure", 32'h1234ABCD, 32'h00000077, 1'b0, 1'b0, 10);

    // Flush in the middle of RUN discards the result.
    req_valid = 1'b1; req_x = 32'd5; req_y = 32'd6; req_signed = 1'b0; req_high = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (11) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_ready", 64'(req_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    check("flush_no_rsp", 64'(seen), 64'd0);
    run_op("after_flush", 32'd7, 32'd9, 1'b0, 1'b0, 0);
    check("after_flush_const", 64'(rsp_result), 64'd63);

    // flush coincident with a request: nothing is accepted.
    req_valid = 1'b1; flush = 1'b1; req_x = 32'd3; req_y = 32'd3;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check("flush_req_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid || busy) seen++;
      tick();
    end
    check("flush_req_no_rsp", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of RUN, not aligned to the clock.
    req_valid = 1'b1; req_x = 32'hCAFEF00D; req_y = 32'h00001234;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(rsp_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(req_ready), 64'd1);
    #7 rst = 1'b1;
    tick();
    run_op("post_reset", 32'h12345678, 32'h00000010, 1'b0, 1'b0, 0);
    check("post_reset_const", 64'(rsp_result), 64'h23456780);

    // Random operands, sign modes, word selects and backpressure.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] rx, ry;
      rx = $urandom;
      ry = $urandom;
      if (n % 6 == 0) rx = 32'h80000000;
      run_op("random", rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
